exu_longpwbck: RTL

EXU_LONGPWBCK -- requirements
Module: exu_longpwbck

---
 rtl/exu_longpwbck.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/exu_longpwbck.sv
// Long-pipe writeback: in-order OITF tracking LSU/MULDIV results, retiring them to the writeback arbiter.
// Optional LONGP_LSU_ERR_EN: LSU bus errors retire silently and raise a one-cycle excp_o_valid pulse.
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef FLEN
`define FLEN 64
`endif

module exu_longpwbck #(
    parameter int unsigned OITF_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic                    disp_rdwen,
    input  logic [`RFIDX_WIDTH-1:0] disp_rdidx,
    input  logic                    disp_unit,
    input  logic                    lsu_wbck_i_valid,
    output logic                    lsu_wbck_i_ready,
    input  logic [`XLEN-1:0]        lsu_wbck_i_wdat,
    input  logic                    lsu_wbck_i_err,
    input  logic                    muldiv_wbck_i_valid,
    output logic                    muldiv_wbck_i_ready,
    input  logic [`XLEN-1:0]        muldiv_wbck_i_wdat,
    output logic                    longp_wbck_o_valid,
    input  logic                    longp_wbck_o_ready,
    output logic [`FLEN-1:0]        longp_wbck_o_wdat,
    output logic [`RFIDX_WIDTH-1:0] longp_wbck_o_rdidx,
    output logic                    oitf_empty,
    output logic                    oitf_full,
    output logic                    excp_o_valid
);

    localparam int unsigned AW = $clog2(OITF_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = `RFIDX_WIDTH;
    localparam int unsigned XW = `XLEN;
    localparam int unsigned FW = `FLEN;

    logic [OITF_DEPTH-1:0] rdwen_q;
    logic [OITF_DEPTH-1:0] unit_q;
    logic [RW-1:0]         rdidx_q [OITF_DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          head_rdwen, head_unit;
    logic          alloc_c, retire_c, lsu_err_c, err_c;
    logic          sel_valid, sel_ready;
    logic [XW-1:0] sel_wdat;

    assign oitf_empty = (cnt_q == '0);
    assign oitf_full  = (cnt_q == CW'(OITF_DEPTH));
    assign disp_ready = ~oitf_full;
    assign alloc_c    = disp_valid & ~oitf_full;

    assign head_rdwen         = rdwen_q[rptr_q];
    assign head_unit          = unit_q[rptr_q];
    assign longp_wbck_o_rdidx = rdidx_q[rptr_q];
    assign longp_wbck_o_wdat  = FW'(sel_wdat);

`ifdef LONGP_LSU_ERR_EN
    assign lsu_err_c = lsu_wbck_i_err;
`else
    logic unused_lsu_err;
    assign unused_lsu_err = lsu_wbck_i_err;
    assign lsu_err_c      = 1'b0;
`endif

    // Only the unit owning the head entry may respond, keeping retirement in program order.
    always_comb begin
        sel_valid           = 1'b0;
        sel_wdat            = '0;
        sel_ready           = 1'b0;
        err_c               = 1'b0;
        longp_wbck_o_valid  = 1'b0;
        lsu_wbck_i_ready    = 1'b0;
        muldiv_wbck_i_ready = 1'b0;
        if (!oitf_empty) begin
            if (head_unit) begin
                sel_valid = muldiv_wbck_i_valid;
                sel_wdat  = muldiv_wbck_i_wdat;
            end else begin
                sel_valid = lsu_wbck_i_valid;
                sel_wdat  = lsu_wbck_i_wdat;
                err_c     = lsu_err_c;
            end
            if (head_rdwen && !err_c) begin
                longp_wbck_o_valid = sel_valid;
                sel_ready          = longp_wbck_o_ready;
            end else begin
                sel_ready = 1'b1;
            end
            lsu_wbck_i_ready    = sel_ready & ~head_unit;
            muldiv_wbck_i_ready = sel_ready & head_unit;
        end
    end

    assign retire_c = sel_valid & sel_ready;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (alloc_c)  wptr_d = wptr_q + AW'(1);
        if (retire_c) rptr_d = rptr_q + AW'(1);
        case ({alloc_c, retire_c})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry payload needs no reset: validity is carried by the count.
    always_ff @(posedge clk) begin
        if (alloc_c) begin
            rdwen_q[wptr_q] <= disp_rdwen;
            unit_q[wptr_q]  <= disp_unit;
            rdidx_q[wptr_q] <= disp_rdidx;
        end
    end

`ifdef LONGP_LSU_ERR_EN
    logic excp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) excp_q <= 1'b0;
        else        excp_q <= retire_c & err_c;
    end

    assign excp_o_valid = excp_q;
`else
    assign excp_o_valid = 1'b0;
`endif

endmodule
